// File: rtl/operand_dispatch_if.sv
// Operand dispatcher handshake bundle: one upstream valid/ready port fanning out to
// NUM_CH registered destination ports, plus the illegal-select pulse.
interface operand_dispatch_if #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
);
  logic                     in_valid;
  logic                     in_ready;
  logic [SEL_W-1:0]         in_sel;
  logic [DATA_W-1:0]        in_data;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH-1:0]        out_ready;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic                     sel_err;

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data, sel_err
  );

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data, sel_err
  );
endinterface

// File: rtl/operand_dispatch.sv
// Registered 1-to-NUM_CH operand dispatcher with one-entry output registers per channel.
// Optional per-channel saturating load counters under OPERAND_DISPATCH_PERF_CNT_EN.
module operand_dispatch #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  operand_dispatch_if.slave    bus
`ifdef OPERAND_DISPATCH_PERF_CNT_EN
  ,
  output logic [NUM_CH*16-1:0] perf_cnt_o
`endif
);

  logic [NUM_CH-1:0]             valid_q;
  logic [NUM_CH-1:0][DATA_W-1:0] data_q;
  logic                          sel_err_q;
  logic                          sel_err_d;
  logic [NUM_CH-1:0]             sel_oh_s;
  logic [NUM_CH-1:0]             load_s;
  logic                          in_ready_s;
  logic                          accept_s;

  // One-hot select decode; an out-of-range select matches no channel.
  always_comb begin
    sel_oh_s = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (bus.in_sel == SEL_W'(k)) begin
        sel_oh_s[k] = 1'b1;
      end else begin
        sel_oh_s[k] = 1'b0;
      end
    end
  end

  // Only the selected channel can stall; an illegal select is always accepted and dropped.
  always_comb begin
    in_ready_s = ~|(sel_oh_s & valid_q & ~bus.out_ready);
    accept_s   = bus.in_valid & in_ready_s;
    load_s     = sel_oh_s & {NUM_CH{accept_s}};
    sel_err_d  = accept_s & ~|sel_oh_s;
  end

  // Per-channel holding registers: a load wins over a same-cycle drain.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q   <= '0;
      data_q    <= '0;
      sel_err_q <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (load_s[k]) begin
          data_q[k]  <= bus.in_data;
          valid_q[k] <= 1'b1;
        end else if (bus.out_ready[k]) begin
          valid_q[k] <= 1'b0;
        end else begin
          valid_q[k] <= valid_q[k];
        end
      end
      sel_err_q <= sel_err_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.sel_err   = sel_err_q;

`ifdef OPERAND_DISPATCH_PERF_CNT_EN
  logic [NUM_CH-1:0][15:0] cnt_q;

  // Load counters saturate at all-ones and clear only on reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (load_s[k] && (cnt_q[k] != 16'hFFFF)) begin
          cnt_q[k] <= cnt_q[k] + 16'd1;
        end else begin
          cnt_q[k] <= cnt_q[k];
        end
      end
    end
  end

  assign perf_cnt_o = cnt_q;
`endif

endmodule

// File: doc/operand_dispatch.md
# operand_dispatch

Registered 1-to-NUM_CH operand dispatcher for the execution stage. It routes one source operand, such as the rs1 value, from decode to the execution unit chosen by an opcode select. Each destination gets its own one-entry output register with a valid/ready handshake. Non-selected units keep their last value and are never given stale or partial updates.

## Interface
Parameters:
- DATA_W, 16, operand width in bits
- NUM_CH, 4, number of destination units (2..16)
- SEL_W, $clog2(NUM_CH), select width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset; sampled on the rising edge of clk
- in_valid  in  1  upstream has an operand
- in_ready  out  1  dispatcher accepts this cycle
- in_sel  in  SEL_W  destination index (opcode field)
- in_data  in  DATA_W  operand value
- out_valid  out  NUM_CH  per-channel operand held
- out_ready  in  NUM_CH  per-channel consumer takes operand
- out_data  out  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
- sel_err  out  1  one-cycle pulse: accepted operand had in_sel >= NUM_CH

## Operation
- Each channel k has a data register D[k] and a valid flag V[k].
- in_ready is combinational:
  - 1 when in_sel >= NUM_CH (the operand is dropped);
  - otherwise !V[in_sel] || out_ready[in_sel].
- Accept = in_valid && in_ready.
- On accept with a legal in_sel = k: D[k] <= in_data and V[k] <= 1, even if channel k is draining in the same cycle.
- Drain: V[k] && out_ready[k] with no new load to k gives V[k] <= 0. D[k] is retained.
- Load and drain on the same channel in the same cycle: the old value is consumed, the new value is loaded, and V[k] stays 1. This gives full throughput with no bubble.
- Drains on other channels proceed in parallel with a load to channel k; the channels are independent.
- Accept with in_sel >= NUM_CH: no register changes; sel_err <= 1 for exactly one cycle.
- out_valid[k] = V[k]; out_data slice k = D[k].
- D[k] only changes on a load. Consumers may sample it whenever V[k]=1.

## Timing
- Latency is 1 cycle: an operand accepted on edge N is visible on out_data/out_valid after edge N.
- Reset (rst_n=0 at a clk edge) gives V=0, D=0, sel_err=0, and the perf counters (if enabled) =0.
  - Reset wins over any simultaneous accept or drain.
  - An in-flight operand is discarded.
- in_ready may go low only while V[in_sel]=1 && out_ready[in_sel]=0.
- Upstream must hold in_valid, in_sel and in_data stable until accept.
- out_valid[k], once asserted, stays high with out_data slice k unchanged until the cycle out_ready[k]=1.
- No combinational path from out_ready[j] to anything except in_ready, and only for j == in_sel.

## Configuration
- Macro OPERAND_DISPATCH_PERF_CNT_EN.
- When defined, adds output perf_cnt of width NUM_CH*16: one 16-bit counter per channel.
  - Each counter increments on every accepted load to that channel.
  - Each counter saturates at 16'hFFFF, with no wrap.
  - Counters are cleared by reset only.
- When undefined, perf_cnt and its logic are absent and the port list is as above.

## Test plan
- Reset and basic route: rst_n=0 for 2 cycles with in_valid=1.
  - During reset, all out_valid=0 and out_data=0.
  - Release, send in_sel=2, in_data=16'h1234 with out_ready=0.
  - Next cycle: out_valid=4'b0100, slice 2=16'h1234, others 0, in_ready for sel 2 now 0.
- Backpressure:
  - With channel 2 full and out_ready[2]=0, present in_sel=2, 16'hBEEF for 3 cycles: in_ready=0 and D[2] stays 16'h1234.
  - Raise out_ready[2]: accept that cycle; next cycle slice 2=16'hBEEF, out_valid[2]=1.
- Back-to-back streaming:
  - out_ready=4'b1111; send in_sel=0,1,2,3,0 with data 1..5 on consecutive cycles.
  - Required: in_ready=1 every cycle, each out_valid high exactly one cycle, channel 0 shows 1 and then 5.
- Parallel drain: channels 1 and 3 both full; in one cycle load channel 1 with 16'h00AA while out_ready=4'b1010.
  - Required: next cycle V=4'b0010, slice 1=16'h00AA, slice 3 value unchanged.
- Illegal select (NUM_CH=3): in_sel=3, in_valid=1.
  - Required: in_ready=1, sel_err pulses for 1 cycle, no V/D change.
- Reset mid-operation and counters:
  - With all channels full, assert rst_n=0 for 1 cycle with a simultaneous accept. Required: all V=0 afterwards.
  - With OPERAND_DISPATCH_PERF_CNT_EN: 70000 loads to channel 0 give perf_cnt[15:0]=16'hFFFF; other counters stay 0.
